x2050ccu: RTL and testbench
===========================

// Module: x2050ccu
// PURPOSE
//  Parametrised 2050 condition-code / program-mask unit; successor of the fixed 32-bit CC register.
//  Sets CC from SS or WM micro-orders on ROS advance and holds CC when neither applies.
//  Adds a CC+mask save stack for mode swaps and a branch-on-condition test output.
//  Sits beside the ALU/T-register datapath; consumed by ROS branch logic and PSW handling.
// PARAMETERS
//  TW      32  T/SDR width in bits; multiple of 8, 16..64
//  SDEPTH  4   save-stack depth in entries, >=1
// PORTS
//  i_clk                  in   1       clock; all state on posedge
//  i_reset                in   1       asynchronous, active-high reset
//  i_ros_advance          in   1       state-update enable
//  i_io_mode              in   1       1 = I/O mode; blocks WM=4
//  i_ce                   in   4       emit field
//  i_ss                   in   6       SS micro-order
//  i_wm                   in   4       WM micro-order
//  i_w_reg                in   8       W register
//  i_bs_reg               in   TW/8    byte-select; bit TW/8-1 selects most-significant byte
//  i_t_reg                in   TW      T register
//  i_sdr                  in   TW      storage data register
//  i_carry, i_c0, i_tzbs  in   1 each  adder carry, carry-0, T-zero-by-bytes
//  i_gpstat               in   8       general-purpose status
//  i_push, i_pop          in   1 each  save/restore {cc,progmask}; sampled only when i_ros_advance=1
//  i_bc_mask              in   4       branch mask; bit 3 tests CC=0
//  o_cc_reg               out  2       condition code
//  o_progmask             out  4       program mask
//  o_bc_taken             out  1       comb: i_bc_mask[3-o_cc_reg]
//  o_stk_full, o_stk_empty out 1 each  stack status
//  o_stk_err              out  1       sticky: push when full or pop when empty
//  o_par_err              out  1       sticky stack parity error (see CONFIGURATION)
//  o_turn_off_load_light  out  1       comb: wm4 & i_ros_advance
// BEHAVIOUR
//  - Reset (async): cc=0, progmask=0, stack empty (ptr=0), stk_err=0, par_err=0.
//  - wm4 = ~i_io_mode & (i_wm==4).
//  - CC sources, by SS code:
//      3  = {0, OR over bytes k (k=0 MSB): bs[TW/8-1-k] & sdr[TW-1-8k]}
//      29 = {carry, |t}
//      40 = ce[1:0]
//      41 = {~t[TW-1] | |t[TW-2:0], t[TW-1]}
//      42 = tzbs?0 : ~c0?1 : 2
//      43 = {~gpstat[3], gpstat[3]}
//      44 = ~code43
//  - Per posedge with i_ros_advance=1, in priority order:
//      1. i_pop and stack non-empty: {cc,pm} <= top, ptr-1; SS/WM CC and mask writes ignored this cycle.
//      2. else cc <= SS value if SS in set above; else w_reg[5:4] if wm4; else hold.
//         progmask <= w_reg[3:0] if wm4, else hold.
//  - Push writes the pre-update {cc,pm} at ptr, ptr+1. Update step 2 still applies the same cycle.
//  - Push and pop together, stack non-empty: exchange. Live <= top; top <= old live; ptr unchanged.
//  - Push when full (ptr==SDEPTH, no pop): no write, stk_err<=1. Pop when empty: no change, stk_err<=1.
//  - Push+pop when empty: pop error flagged, push performed.
//  - i_ros_advance=0: all state holds; i_push/i_pop ignored.
//  - o_stk_full = ptr==SDEPTH; o_stk_empty = ptr==0; ptr width clog2(SDEPTH+1).
//  - Sticky errors clear only on reset.
// CONFIGURATION
//  X2050CCU_PARITY_EN defined:
//    - each stack entry stores an odd-parity bit over its 6 data bits;
//    - a successful pop (or exchange) whose read entry fails the check sets o_par_err=1;
//    - the data is still restored.
//  Not defined: no parity storage; o_par_err tied 0.
// TESTING
//  - Reset mid-run: cc=2, pm=5, 2 entries pushed; assert i_reset -> all outputs 0 and stk_empty=1 immediately (async).
//  - ss=29, carry=1, t=0, advance -> cc=2. Then ss=0, wm=0, advance -> cc stays 2 (hold).
//  - wm=4, io_mode=0, w=0x2A, advance -> cc=2, pm=0xA, turn_off_load_light=1 that cycle; io_mode=1 -> no change, light=0.
//  - SDEPTH=4: 4 pushes then 5th -> stk_full=1, stk_err=1, contents intact; 4 pops restore LIFO order; extra pop -> stays empty.
//  - Exchange: live {1,3}, top {2,9}, push+pop -> live {2,9}, top {1,3}, ptr unchanged.
//  - TW=64, ss=3, bs=0x80, sdr[63]=1 -> cc=1; bc_mask=4'b0100 -> bc_taken=1.

Source files
------------

// File: rtl/x2050ccu.sv
// rtl/x2050ccu.sv - 2050 condition-code / program-mask unit with CC+mask save stack
// Optional odd-parity protection of stack entries when X2050CCU_PARITY_EN is defined.
module x2050ccu #(
    parameter int TW     = 32,
    parameter int SDEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_ros_advance,
    input  logic            i_io_mode,
    input  logic [3:0]      i_ce,
    input  logic [5:0]      i_ss,
    input  logic [3:0]      i_wm,
    input  logic [7:0]      i_w_reg,
    input  logic [TW/8-1:0] i_bs_reg,
    input  logic [TW-1:0]   i_t_reg,
    input  logic [TW-1:0]   i_sdr,
    input  logic            i_carry,
    input  logic            i_c0,
    input  logic            i_tzbs,
    input  logic [7:0]      i_gpstat,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [3:0]      i_bc_mask,
    output logic [1:0]      o_cc_reg,
    output logic [3:0]      o_progmask,
    output logic            o_bc_taken,
    output logic            o_stk_full,
    output logic            o_stk_empty,
    output logic            o_stk_err,
    output logic            o_par_err,
    output logic            o_turn_off_load_light
);

    localparam int NB = TW / 8;
    localparam int PW = $clog2(SDEPTH + 1);
`ifdef X2050CCU_PARITY_EN
    localparam int EW = 7;
`else
    localparam int EW = 6;
`endif

    logic [1:0]    cc_q, cc_d;
    logic [3:0]    pm_q, pm_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [EW-1:0] stk_q [SDEPTH];
    logic [EW-1:0] stk_d [SDEPTH];
    logic          stk_err_q, stk_err_d;
`ifdef X2050CCU_PARITY_EN
    logic          par_err_q, par_err_d;
`endif

    logic          wm4, ss_hit, sdr_sign, stk_full, stk_empty, pop_ok, wr_en;
    logic [1:0]    ss_cc;
    logic [5:0]    live;
    logic [PW-1:0] top_idx, wr_idx;
    logic [EW-1:0] top_ent, wr_ent;
    logic          unused_inputs;

    assign unused_inputs = ^{i_ce[3:2], i_w_reg[7:6], i_gpstat[7:4], i_gpstat[2:0], i_sdr};

    assign wm4       = ~i_io_mode & (i_wm == 4'd4);
    assign stk_full  = (ptr_q == PW'(SDEPTH));
    assign stk_empty = (ptr_q == '0);
    assign live      = {cc_q, pm_q};
    assign top_idx   = ptr_q - PW'(1);

`ifdef X2050CCU_PARITY_EN
    assign wr_ent = {~^live, live};
`else
    assign wr_ent = live;
`endif

    // Sign bit of each byte, qualified by its byte-select bit.
    always_comb begin
        sdr_sign = 1'b0;
        for (int j = 0; j < NB; j++) begin
            sdr_sign = sdr_sign | (i_bs_reg[j] & i_sdr[8*j+7]);
        end
        ss_hit = 1'b1;
        ss_cc  = 2'd0;
        case (i_ss)
            6'd3:    ss_cc = {1'b0, sdr_sign};
            6'd29:   ss_cc = {i_carry, |i_t_reg};
            6'd40:   ss_cc = i_ce[1:0];
            6'd41:   ss_cc = {~i_t_reg[TW-1] | (|i_t_reg[TW-2:0]), i_t_reg[TW-1]};
            6'd42:   ss_cc = i_tzbs ? 2'd0 : (~i_c0 ? 2'd1 : 2'd2);
            6'd43:   ss_cc = {~i_gpstat[3], i_gpstat[3]};
            6'd44:   ss_cc = {i_gpstat[3], ~i_gpstat[3]};
            default: ss_hit = 1'b0;
        endcase
    end

    always_comb begin
        top_ent = '0;
        for (int i = 0; i < SDEPTH; i++) begin
            if (PW'(i) == top_idx) top_ent = stk_q[i];
        end
    end

    always_comb begin
        cc_d      = cc_q;
        pm_d      = pm_q;
        ptr_d     = ptr_q;
        stk_err_d = stk_err_q;
`ifdef X2050CCU_PARITY_EN
        par_err_d = par_err_q;
`endif
        wr_en     = 1'b0;
        wr_idx    = ptr_q;
        pop_ok    = i_pop & ~stk_empty;
        if (i_ros_advance) begin
            if (pop_ok) begin
                // A push alongside a good pop becomes an exchange with the top entry.
                {cc_d, pm_d} = top_ent[5:0];
`ifdef X2050CCU_PARITY_EN
                if (^top_ent != 1'b1) par_err_d = 1'b1;
`endif
                if (i_push) begin
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end else begin
                    ptr_d = top_idx;
                end
            end else begin
                if (i_pop) stk_err_d = 1'b1;
                if (ss_hit) cc_d = ss_cc;
                else if (wm4) cc_d = i_w_reg[5:4];
                if (wm4) pm_d = i_w_reg[3:0];
                if (i_push) begin
                    if (stk_full) begin
                        stk_err_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        ptr_d = ptr_q + PW'(1);
                    end
                end
            end
        end
        for (int i = 0; i < SDEPTH; i++) begin
            stk_d[i] = (wr_en && (PW'(i) == wr_idx)) ? wr_ent : stk_q[i];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cc_q      <= 2'd0;
            pm_q      <= 4'd0;
            ptr_q     <= '0;
            stk_err_q <= 1'b0;
            for (int i = 0; i < SDEPTH; i++) stk_q[i] <= '0;
        end else begin
            cc_q      <= cc_d;
            pm_q      <= pm_d;
            ptr_q     <= ptr_d;
            stk_err_q <= stk_err_d;
            for (int i = 0; i < SDEPTH; i++) stk_q[i] <= stk_d[i];
        end
    end

`ifdef X2050CCU_PARITY_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) par_err_q <= 1'b0;
        else         par_err_q <= par_err_d;
    end
    assign o_par_err = par_err_q;
`else
    assign o_par_err = 1'b0;
`endif

    assign o_cc_reg              = cc_q;
    assign o_progmask            = pm_q;
    assign o_bc_taken            = i_bc_mask[~cc_q];
    assign o_stk_full            = stk_full;
    assign o_stk_empty           = stk_empty;
    assign o_stk_err             = stk_err_q;
    assign o_turn_off_load_light = wm4 & i_ros_advance;

endmodule

// File: tb/tb_x2050ccu.sv
// tb/tb_x2050ccu.sv - randomized bench for x2050ccu against a queue-based reference model
module tb_x2050ccu;
    localparam int TW     = 64;
    localparam int SDEPTH = 4;
    localparam int NB     = TW / 8;

    logic          clk = 1'b0, rst = 1'b0;
    logic          adv, io, carry, c0, tzbs, push, pop;
    logic [3:0]    ce, wm, bc_mask;
    logic [5:0]    ss;
    logic [7:0]    w, gpstat;
    logic [NB-1:0] bs;
    logic [TW-1:0] t, sdr;
    logic [1:0]    o_cc;
    logic [3:0]    o_pm;
    logic          o_bc, o_full, o_empty, o_err, o_perr, o_light;

    x2050ccu #(.TW(TW), .SDEPTH(SDEPTH)) dut (
        .i_clk(clk), .i_reset(rst), .i_ros_advance(adv), .i_io_mode(io),
        .i_ce(ce), .i_ss(ss), .i_wm(wm), .i_w_reg(w), .i_bs_reg(bs),
        .i_t_reg(t), .i_sdr(sdr), .i_carry(carry), .i_c0(c0), .i_tzbs(tzbs),
        .i_gpstat(gpstat), .i_push(push), .i_pop(pop), .i_bc_mask(bc_mask),
        .o_cc_reg(o_cc), .o_progmask(o_pm), .o_bc_taken(o_bc),
        .o_stk_full(o_full), .o_stk_empty(o_empty), .o_stk_err(o_err),
        .o_par_err(o_perr), .o_turn_off_load_light(o_light)
    );

    always #5 clk = ~clk;

    int         total = 0, bad = 0;
    bit         chk_en = 1'b0;
    logic [1:0] m_cc;
    logic [3:0] m_pm;
    logic       m_err;
    logic [5:0] m_stk[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Returns {valid, cc} for the SS micro-order from the current inputs.
    function automatic logic [2:0] ss_ref();
        logic s;
        s = 1'b0;
        for (int k = 0; k < NB; k++) s = s | (bs[NB-1-k] & sdr[TW-1-8*k]);
        case (ss)
            6'd3:    return {1'b1, 1'b0, s};
            6'd29:   return {1'b1, carry, t != 0};
            6'd40:   return {1'b1, ce[1:0]};
            6'd41:   return {1'b1, (!t[TW-1]) || (t[TW-2:0] != 0), t[TW-1]};
            6'd42:   return {1'b1, tzbs ? 2'd0 : (!c0 ? 2'd1 : 2'd2)};
            6'd43:   return {1'b1, !gpstat[3], gpstat[3]};
            6'd44:   return {1'b1, gpstat[3], !gpstat[3]};
            default: return 3'b000;
        endcase
    endfunction

    task automatic model_update();
        logic [5:0] e, old;
        logic [2:0] r;
        logic       m_wm4;
        if (!adv) return;
        m_wm4 = !io && (wm == 4'd4);
        if (pop && m_stk.size() > 0) begin
            e = m_stk.pop_back();
            if (push) m_stk.push_back({m_cc, m_pm});
            {m_cc, m_pm} = e;
        end else begin
            if (pop) m_err = 1'b1;
            old = {m_cc, m_pm};
            r = ss_ref();
            if (r[2]) m_cc = r[1:0];
            else if (m_wm4) m_cc = w[5:4];
            if (m_wm4) m_pm = w[3:0];
            if (push) begin
                if (m_stk.size() == SDEPTH) m_err = 1'b1;
                else m_stk.push_back(old);
            end
        end
    endtask

    task automatic model_reset();
        m_cc = 2'd0; m_pm = 4'd0; m_err = 1'b0;
        m_stk.delete();
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("cc", o_cc, m_cc);
            chk("progmask", o_pm, m_pm);
            chk("stk_full", o_full, m_stk.size() == SDEPTH);
            chk("stk_empty", o_empty, m_stk.size() == 0);
            chk("stk_err", o_err, m_err);
            chk("par_err", o_perr, 1'b0);
            chk("bc_taken", o_bc, bc_mask[3-int'(m_cc)]);
            chk("load_light", o_light, adv && !io && (wm == 4'd4));
        end
    end

    task automatic clear_inputs();
        adv = 0; io = 0; carry = 0; c0 = 0; tzbs = 0; push = 0; pop = 0;
        ce = 0; wm = 0; bc_mask = 0; ss = 0; w = 0; gpstat = 0; bs = 0; t = 0; sdr = 0;
    endtask

    task automatic go();
        @(posedge clk);
        model_update();
        #1;
        adv = 0; push = 0; pop = 0; ss = 0; wm = 0;
    endtask

    task automatic randomize_inputs();
        adv     = ($urandom_range(0, 9) != 0);
        push    = ($urandom_range(0, 2) == 0);
        pop     = ($urandom_range(0, 2) == 0);
        io      = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 8))
            0: ss = 6'd3;   1: ss = 6'd29;  2: ss = 6'd40;
            3: ss = 6'd41;  4: ss = 6'd42;  5: ss = 6'd43;
            6: ss = 6'd44;  7: ss = 6'd0;   default: ss = 6'($urandom);
        endcase
        wm      = ($urandom_range(0, 2) == 0) ? 4'd4 : 4'($urandom);
        w       = 8'($urandom);
        ce      = 4'($urandom);
        carry   = 1'($urandom); c0 = 1'($urandom); tzbs = 1'($urandom);
        gpstat  = 8'($urandom);
        bs      = NB'($urandom);
        bc_mask = 4'($urandom);
        sdr     = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: t = '0;
            1: t = 64'h8000_0000_0000_0000;
            default: t = {$urandom, $urandom};
        endcase
    endtask

    initial begin
        logic [5:0] exp_pop [4];
        exp_pop[0] = {2'd3, 4'd3}; exp_pop[1] = {2'd2, 4'd2};
        exp_pop[2] = {2'd1, 4'd1}; exp_pop[3] = {2'd2, 4'hA};
        clear_inputs();
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_cc", o_cc, 2'd0);
        chk("rst_pm", o_pm, 4'd0);
        chk("rst_empty", o_empty, 1'b1);
        chk("rst_full", o_full, 1'b0);
        chk("rst_err", o_err, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        chk_en = 1'b1;

        ss = 6'd29; carry = 1; t = '0; adv = 1; go();
        chk("ss29_cc", o_cc, 2'd2);
        carry = 0;
        adv = 1; go();
        chk("hold_cc", o_cc, 2'd2);

        wm = 4'd4; w = 8'h2A; adv = 1; #1;
        chk("light_on", o_light, 1'b1);
        go();
        chk("wm4_cc", o_cc, 2'd2);
        chk("wm4_pm", o_pm, 4'hA);
        io = 1; wm = 4'd4; w = 8'h15; adv = 1; #1;
        chk("light_io", o_light, 1'b0);
        go();
        chk("io_pm", o_pm, 4'hA);
        io = 0;

        for (int i = 0; i < 4; i++) begin
            wm = 4'd4; w = 8'((i == 3) ? 8'h04 : 8'h11 * (i + 1)); push = 1; adv = 1; go();
        end
        chk("four_full", o_full, 1'b1);
        push = 1; adv = 1; go();
        chk("over_err", o_err, 1'b1);
        chk("over_live", {o_cc, o_pm}, {2'd0, 4'd4});
        for (int i = 0; i < 4; i++) begin
            pop = 1; adv = 1; go();
            chk("lifo_pop", {o_cc, o_pm}, exp_pop[i]);
        end
        pop = 1; adv = 1; go();
        chk("under_empty", o_empty, 1'b1);
        chk("under_live", {o_cc, o_pm}, {2'd2, 4'hA});

        wm = 4'd4; w = 8'h29; adv = 1; go();
        wm = 4'd4; w = 8'h13; push = 1; adv = 1; go();
        chk("xchg_pre", {o_cc, o_pm}, {2'd1, 4'd3});
        push = 1; pop = 1; adv = 1; go();
        chk("xchg_live", {o_cc, o_pm}, {2'd2, 4'd9});
        chk("xchg_ptr", {o_empty, o_full}, 2'b00);
        pop = 1; adv = 1; go();
        chk("xchg_top", {o_cc, o_pm}, {2'd1, 4'd3});
        chk("xchg_empty", o_empty, 1'b1);

        push = 1; pop = 1; wm = 4'd4; w = 8'h3F; adv = 0; go();
        chk("noadv_live", {o_cc, o_pm}, {2'd1, 4'd3});
        chk("noadv_empty", o_empty, 1'b1);

        ss = 6'd3; bs = 8'h80; sdr = 64'h8000_0000_0000_0000; adv = 1; go();
        chk("ss3_cc", o_cc, 2'd1);
        bc_mask = 4'b0100; #1;
        chk("bc_taken", o_bc, 1'b1);

        for (int n = 0; n < 1500; n++) begin
            randomize_inputs();
            go();
        end

        clear_inputs();
        wm = 4'd4; w = 8'h25; push = 1; adv = 1; go();
        wm = 4'd4; w = 8'h25; push = 1; adv = 1; go();
        chk("pre_rst", {o_cc, o_pm}, {2'd2, 4'd5});
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_cc", o_cc, 2'd0);
        chk("mid_rst_pm", o_pm, 4'd0);
        chk("mid_rst_empty", o_empty, 1'b1);
        chk("mid_rst_err", {o_err, o_perr, o_full}, 3'b000);
        @(posedge clk); #1 rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
